// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: widths, reset PC, opcode map, FSM encoding.
// Optional performance counters in fetch_unit are enabled with the FETCH_PERF_EN macro.
package fetch_pkg;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC = 12'h000;

    localparam logic [3:0] OP_ALU_LO  = 4'h0;
    localparam logic [3:0] OP_ALU_HI  = 4'h7;
    localparam logic [3:0] OP_IMM_LO  = 4'h8;
    localparam logic [3:0] OP_IMM_HI  = 4'hB;
    localparam logic [3:0] OP_NOWR_LO = 4'hC;
    localparam logic [3:0] OP_NOWR_HI = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    function automatic logic op_is_imm(input logic [3:0] op);
        return (op >= OP_IMM_LO) && (op <= OP_IMM_HI);
    endfunction

    // Register-reg and immediate ALU ops both write back; 0xC and above do not.
    function automatic logic op_writes_reg(input logic [3:0] op);
        return op <= OP_IMM_HI;
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry queue of {PC, instruction} words between the ROM and execute.
// Flush clears the queue after any same-cycle pop; head is presented combinationally.
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter int W = ADDR_W + INSTR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         pop_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC into a 1-cycle ROM, queues returned words, handles
// branch redirects and HALT. Define FETCH_PERF_EN to add pop/stall performance counters.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               br_taken_i,
    input  logic [ADDR_W-1:0]  br_target_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ADDR_W-1:0]  out_pc_o,
    output logic [3:0]         out_opcode_o,
    output logic [3:0]         out_opa_o,
    output logic [3:0]         out_opb_o,
    output logic [3:0]         out_opc_o,
    output logic [11:0]        out_addrimm_o,
    output logic               out_isimm_o,
    output logic               out_wen_o,
`ifdef FETCH_PERF_EN
    output logic [15:0]        perf_issued_o,
    output logic [15:0]        perf_stall_o,
`endif
    output logic               halted_o
);

    fetch_state_e              state_q, state_d;
    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic                      infl_q, infl_d;
    logic [ADDR_W-1:0]         infl_pc_q, infl_pc_d;
    logic                      flush;
    logic                      push;
    logic                      pop;
    logic                      halt_pop;
    logic                      issue;
    logic [2:0]                occ;
    logic [1:0]                count;
    logic [ADDR_W+INSTR_W-1:0] head;
    logic [INSTR_W-1:0]        head_instr;

    assign head_instr  = head[INSTR_W-1:0];
    assign out_valid_o = (count != 2'd0);
    assign pop         = out_valid_o && out_ready_i;
    assign halt_pop    = pop && (head_instr[15:12] == OP_HALT);
    // Words already queued or in flight, minus the one leaving this cycle, must leave room.
    assign occ         = {1'b0, count} + {2'b0, infl_q} - {2'b0, pop};
    assign issue       = (occ < 3'd2);
    assign push        = infl_q && !flush;

    fetch_skid_fifo #(.W(ADDR_W + INSTR_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  ({infl_pc_q, imem_data_i}),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        infl_d    = 1'b0;
        infl_pc_d = infl_pc_q;
        flush     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_pop) begin
                    state_d = ST_HALTED;
                    flush   = 1'b1;
                end else if (br_taken_i) begin
                    pc_d  = br_target_i;
                    flush = 1'b1;
                end else if (issue) begin
                    pc_d      = pc_q + 1'b1;
                    infl_d    = 1'b1;
                    infl_pc_d = pc_q;
                end
            end
            ST_HALTED: begin
                if (start_i) begin
                    state_d = ST_IDLE;
                    pc_d    = RESET_PC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign halted_o      = (state_q == ST_HALTED);
    assign out_pc_o      = head[ADDR_W+INSTR_W-1:INSTR_W];
    assign out_opcode_o  = head_instr[15:12];
    assign out_opa_o     = head_instr[11:8];
    assign out_opb_o     = head_instr[7:4];
    assign out_opc_o     = head_instr[3:0];
    assign out_addrimm_o = head_instr[11:0];
    assign out_isimm_o   = op_is_imm(head_instr[15:12]);
    assign out_wen_o     = op_writes_reg(head_instr[15:12]);

`ifdef FETCH_PERF_EN
    logic [15:0] perf_issued_q;
    logic [15:0] perf_stall_q;
    logic        perf_clr;
    logic        stall;

    assign perf_clr = (state_q == ST_HALTED) && start_i;
    assign stall    = (state_q == ST_RUN) && out_valid_o && !out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= 16'd0;
            perf_stall_q  <= 16'd0;
        end else if (perf_clr) begin
            perf_issued_q <= 16'd0;
            perf_stall_q  <= 16'd0;
        end else begin
            if (pop && (perf_issued_q != 16'hFFFF)) perf_issued_q <= perf_issued_q + 16'd1;
            if (stall && (perf_stall_q != 16'hFFFF)) perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule
